exp_bit_scanner: RTL and testbench

//  Reads an RSA exponent MSB-first and emits one bit per accepted handshake to the square-and-multiply controller.

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/bit_down_counter.sv | 42 ++++
 rtl/exp_bit_scanner.sv | 131 +++++++++++++
 tb/tb_exp_bit_scanner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA exponent scanning path.
// Build option: EXP_SCAN_SKIP_LZ_EN enables leading-zero skipping in exp_bit_scanner.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  localparam int EXP_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF = $clog2(EXP_WIDTH_DEF) + 1;

  // True while a scan is consuming bits (leading-zero skip or emitting).
  function automatic logic is_busy_state(input scan_state_t s);
    return (s == SKIP) || (s == SHIFT);
  endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter for the remaining-bit count. Saturates at zero and
// exposes zero/one flags so the scanner can spot the final bit without
// a separate comparator.
module bit_down_counter #(
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec_en,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 is_zero,
  output logic                 is_one
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  // Next count: load wins over decrement; decrement never goes below zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec_en && (count_q != '0)) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign is_zero = (count_q == '0);
  assign is_one  = (count_q == CNT_WIDTH'(1));

endmodule

// File: rtl/exp_bit_scanner.sv
// Exponent bit scanner: loads an exponent and presents its low nbits one at
// a time, MSB first, over a valid/ready handshake to the modexp controller.
// Build option: define EXP_SCAN_SKIP_LZ_EN to drop leading zeros of the
// scanned field before the first emitted bit.
module exp_bit_scanner
  import rsa_pkg::*;
#(
  parameter int EXP_WIDTH = EXP_WIDTH_DEF,
  parameter int CNT_WIDTH = $clog2(EXP_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic [CNT_WIDTH-1:0] nbits,
  output logic                 bit_out,
  output logic                 bit_valid,
  input  logic                 bit_ready,
  output logic                 bit_last,
  output logic [CNT_WIDTH-1:0] remaining,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_WIDTH-1:0] EXP_WIDTH_C = CNT_WIDTH'(EXP_WIDTH);

`ifdef EXP_SCAN_SKIP_LZ_EN
  localparam scan_state_t LOAD_TARGET = SKIP;
`else
  localparam scan_state_t LOAD_TARGET = SHIFT;
`endif

  scan_state_t          state_q, state_d;
  logic [EXP_WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_WIDTH-1:0] n_clamped;
  logic [CNT_WIDTH-1:0] align_shift;
  logic [CNT_WIDTH-1:0] cnt_value;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_is_zero;
  logic                 cnt_is_one;
  logic                 sreg_msb;

  assign sreg_msb = sreg_q[EXP_WIDTH-1];

  // Clamp the requested length and left-align the field so its MSB sits at the top of sreg.
  always_comb begin
    n_clamped   = (nbits > EXP_WIDTH_C) ? EXP_WIDTH_C : nbits;
    align_shift = EXP_WIDTH_C - n_clamped;
  end

  bit_down_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_remaining (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(n_clamped),
    .dec_en  (cnt_dec),
    .count   (cnt_value),
    .is_zero (cnt_is_zero),
    .is_one  (cnt_is_one)
  );

  // Next-state, shift-register and counter control.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // A new start is only accepted here; while busy it is ignored.
        if (start) begin
          sreg_d   = exp_in << align_shift;
          cnt_load = 1'b1;
          state_d  = (n_clamped == '0) ? DONE : LOAD_TARGET;
        end
      end
`ifdef EXP_SCAN_SKIP_LZ_EN
      SKIP: begin
        // Discard leading zeros silently; an all-zero field finishes with nothing emitted.
        if (sreg_msb) begin
          state_d = SHIFT;
        end else begin
          sreg_d  = sreg_q << 1;
          cnt_dec = !cnt_is_zero;
          if (cnt_is_one || cnt_is_zero) begin
            state_d = DONE;
          end
        end
      end
`endif
      SHIFT: begin
        // Advance only on an accepted handshake so the presented bit stays stable.
        if (bit_ready) begin
          sreg_d  = sreg_q << 1;
          cnt_dec = !cnt_is_zero;
          if (cnt_is_one || cnt_is_zero) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and shift-register flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

  // Outputs are decoded from registered state, so they are glitch-free and handshake-independent.
  always_comb begin
    bit_valid = (state_q == SHIFT);
    bit_out   = (state_q == SHIFT) && sreg_msb;
    bit_last  = (state_q == SHIFT) && cnt_is_one;
    busy      = is_busy_state(state_q);
    done      = (state_q == DONE);
    remaining = (state_q == DONE) ? '0 : cnt_value;
  end

endmodule

// File: tb/tb_exp_bit_scanner.sv
// Randomized self-checking bench for exp_bit_scanner. The reference model
// builds the expected bit stream directly from the exponent value.
module tb_exp_bit_scanner;

  localparam int EW = 32;
  localparam int CW = 6;
  localparam int BUDGET = 200;

`ifdef EXP_SCAN_SKIP_LZ_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [EW-1:0] exp_in = '0;
  logic [CW-1:0] nbits = '0;
  logic          bit_out;
  logic          bit_valid;
  logic          bit_ready = 1'b0;
  logic          bit_last;
  logic [CW-1:0] remaining;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_mis = 0;

  bit exp_q[$];
  int exp_lz;
  int exp_n;

  exp_bit_scanner #(
    .EXP_WIDTH(EW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .exp_in   (exp_in),
    .nbits    (nbits),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .bit_last (bit_last),
    .remaining(remaining),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected stream: low n bits of the exponent, MSB first, leading zeros dropped when skipping.
  task automatic model_load(input logic [31:0] e, input int nb);
    exp_n  = (nb > EW) ? EW : nb;
    exp_lz = 0;
    exp_q.delete();
    for (int i = exp_n - 1; i >= 0; i--) exp_q.push_back(e[i]);
    if (SKIP_EN) begin
      while (exp_q.size() > 0 && exp_q[0] == 1'b0) begin
        void'(exp_q.pop_front());
        exp_lz++;
      end
    end
  endtask

  // ready_mode: 0 always ready, 1 toggling, 2 random. poke pulses start mid-scan.
  task automatic run_scan(input string name, input logic [31:0] e, input int nb,
                          input int ready_mode, input bit poke);
    int  cyc;
    int  emitted;
    bit  seen_valid;
    bit  prev_stall;
    bit  prev_bit;
    bit  timed_out;
    @(negedge clk);
    exp_in = e;
    nbits  = CW'(nb);
    start  = 1'b1;
    model_load(e, nb);
    @(negedge clk);
    start  = 1'b0;
    exp_in = $urandom;
    nbits  = CW'($urandom_range(0, 40));
    check({name, ":busy_after_start"}, 32'(busy), 32'(exp_n > 0));
    check({name, ":done_after_start"}, 32'(done), 32'(exp_n == 0));
    emitted    = 0;
    seen_valid = 1'b0;
    prev_stall = 1'b0;
    prev_bit   = 1'b0;
    timed_out  = 1'b1;
    for (cyc = 1; cyc <= BUDGET; cyc++) begin
      start = 1'b0;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (prev_stall) begin
        check({name, ":hold_valid"}, 32'(bit_valid), 32'd1);
        check({name, ":hold_bit"}, 32'(bit_out), 32'(prev_bit));
      end
      case (ready_mode)
        0:       bit_ready = 1'b1;
        1:       bit_ready = cyc[0];
        default: bit_ready = 1'($urandom_range(0, 1));
      endcase
      if (bit_valid && !seen_valid) begin
        seen_valid = 1'b1;
        check({name, ":first_bit_latency"}, 32'(cyc), 32'(1 + exp_lz));
      end
      if (bit_valid) begin
        if (exp_q.size() == 0) begin
          check({name, ":unexpected_valid"}, 32'd1, 32'd0);
        end else begin
          check({name, ":remaining"}, 32'(remaining), 32'(exp_q.size()));
          check({name, ":bit_last"}, 32'(bit_last), 32'(exp_q.size() == 1));
          if (bit_ready) begin
            check({name, ":bit_out"}, 32'(bit_out), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            emitted++;
          end
        end
      end
      prev_stall = bit_valid && !bit_ready;
      prev_bit   = bit_out;
      if (poke && cyc == 2 && busy) begin
        start  = 1'b1;
        exp_in = $urandom;
        nbits  = CW'($urandom_range(1, 32));
      end
      @(negedge clk);
    end
    start     = 1'b0;
    bit_ready = 1'b0;
    if (timed_out) begin
      check({name, ":timeout"}, 32'd1, 32'd0);
    end
    check({name, ":end_done"}, 32'(done), 32'd1);
    check({name, ":end_remaining"}, 32'(remaining), 32'd0);
    check({name, ":end_busy"}, 32'(busy), 32'd0);
    check({name, ":end_valid"}, 32'(bit_valid), 32'd0);
    check({name, ":bits_left_in_model"}, 32'(exp_q.size()), 32'd0);
    $display("scan %s exp=%08h nbits=%0d n=%0d skipped=%0d emitted=%0d", name, e, nb, exp_n, exp_lz, emitted);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    #13;
    check("reset:bit_valid", 32'(bit_valid), 32'd0);
    check("reset:bit_out", 32'(bit_out), 32'd0);
    check("reset:bit_last", 32'(bit_last), 32'd0);
    check("reset:busy", 32'(busy), 32'd0);
    check("reset:done", 32'(done), 32'd0);
    check("reset:remaining", 32'(remaining), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-scan, not aligned to a clock edge.
    @(negedge clk);
    exp_in = 32'hFFFF_FFFF;
    nbits  = CW'(32);
    start  = 1'b1;
    bit_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst:busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst:bit_valid", 32'(bit_valid), 32'd0);
    check("midrst:bit_out", 32'(bit_out), 32'd0);
    check("midrst:busy", 32'(busy), 32'd0);
    check("midrst:done", 32'(done), 32'd0);
    check("midrst:remaining", 32'(remaining), 32'd0);
    #4 rst = 1'b0;
    bit_ready = 1'b0;
    $display("scan midrst: reset asserted during SHIFT");

    run_scan("exp5_n3", 32'h0000_0005, 3, 0, 1'b0);
    run_scan("backpressure_A", 32'h0000_000A, 4, 1, 1'b0);
    run_scan("nbits0", 32'hDEAD_BEEF, 0, 0, 1'b0);
    run_scan("nbits40", 32'h8000_0001, 40, 0, 1'b0);
    run_scan("lz_11", 32'h0000_0011, 32, 0, 1'b0);
    run_scan("all_zero", 32'h0000_0000, 32, 2, 1'b0);
    run_scan("poke_busy", 32'h0000_00F3, 8, 2, 1'b1);
    run_scan("restart_done", 32'hC000_0000, 32, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      r = $urandom >> $urandom_range(0, 31);
      run_scan($sformatf("rand%0d", i), r, $urandom_range(0, 40), $urandom_range(0, 2), 1'(i % 5 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
